hilo_mul_ctrl: RTL and testbench
================================

// Module: hilo_mul_ctrl
// PURPOSE
//  Sequential front/back end for the combinational 32x32 unsigned multiplier (Mul32).
//  Accepts MULT/MULTU requests and drives registered magnitudes into Mul32.
//  Captures its 64-bit product, applies the sign fix-up and writes the HI/LO pair.
//  Also services MTHI/MTLO writes and exposes HI/LO to the register-read path.
// PARAMETERS
//  W        32  operand width; HI/LO are W bits each, product is 2W
// PORTS
//  clk       in   1    system clock, rising edge
//  rst       in   1    synchronous reset, active-high
//  start     in   1    request multiply; sampled only in IDLE
//  op_signed in   1    1 = MULT (two's complement), 0 = MULTU
//  a         in   W    multiplicand (rs)
//  b         in   W    multiplier (rt)
//  hi_we     in   1    MTHI write strobe
//  lo_we     in   1    MTLO write strobe
//  wdata     in   W    MTHI/MTLO data
//  mul_a     out  W    operand to Mul32 a (registered)
//  mul_b     out  W    operand to Mul32 b (registered)
//  mul_prod  in   2W   Mul32 prod (combinational from mul_a/mul_b)
//  hi        out  W    HI register
//  lo        out  W    LO register
//  busy      out  1    1 when state != IDLE; pipeline stalls MFHI/MFLO/MULT on it
//  done      out  1    1-cycle pulse, HI/LO hold the new product
// BEHAVIOUR
//  Reset (sync): state=IDLE; hi=lo=0; mul_a=mul_b=0; prod_r=0; neg=0; done=0.
//    Reset wins over every other input, including mid-operation.
//    An in-flight multiply is discarded; HI/LO are not written.
//  FSM has three states: IDLE, CALC, FIX.
//  IDLE, start=1 at edge E0:
//    mul_a <= (op_signed & a[W-1]) ? -a : a
//    mul_b <= (op_signed & b[W-1]) ? -b : b
//    neg   <= op_signed & (a[W-1]^b[W-1])
//    state -> CALC
//  CALC at edge E1: prod_r <= mul_prod; state -> FIX.
//  FIX at edge E2:
//    {hi,lo} <= neg ? (~prod_r + 1) : prod_r   (2W-bit two's complement)
//    done <= 1; state -> IDLE
//  done is high for exactly the cycle after E2; otherwise 0.
//  Latency: start seen at E0; HI/LO valid and done=1 after E2.
//    A new start is accepted at E3 at the earliest.
//  busy is combinational from state: 1 in CALC and FIX, 0 in IDLE (including the done cycle).
//  start while busy: ignored. No queueing, no error flag.
//  hi_we/lo_we in IDLE: hi<=wdata / lo<=wdata at that edge.
//    Both strobes may be asserted together.
//  hi_we/lo_we while busy: ignored. The CPU stalls them on busy.
//  start and hi_we/lo_we in the same IDLE cycle: both are accepted.
//    The MT write lands at E0; the product overwrites HI/LO at E2.
//  Magnitude of the most-negative value (0x8000_0000) is 0x8000_0000, treated as unsigned.
//    This is correct because Mul32 is unsigned.
//  Zero product with neg=1 negates to 0; no negative zero exists.
//  mul_a/mul_b hold their values after the operation until the next accepted start.
// TESTING
//  1 MULTU a=FFFF_FFFF b=FFFF_FFFF -> after E2 hi=FFFF_FFFE lo=0000_0001; done pulses 1 cycle.
//  2 MULT a=FFFF_FFFD(-3) b=0000_0005 -> hi=FFFF_FFFF lo=FFFF_FFF1; mul_a=3 mul_b=5 during CALC.
//  3 MULT a=b=8000_0000 -> hi=4000_0000 lo=0;
//    MULT a=8000_0000 b=1 -> hi=FFFF_FFFF lo=8000_0000.
//  4 start again in CALC/FIX with a=7 -> ignored; HI/LO take the first result; busy=1 for 2 cycles.
//  5 hi_we=1 wdata=1234_5678 with start (MULTU 2*3) -> hi=1234_5678 after E0; hi=0 lo=6 after E2;
//    lo_we while busy -> lo unchanged.
//  6 rst=1 in FIX -> next cycle state=IDLE, hi=lo=0, done=0, busy=0; MULTU 4*4 afterwards gives lo=16.

Source files
------------

// File: rtl/hilo_mul_ctrl_if.sv
// HI/LO multiply controller bus: CPU request side plus the Mul32 operand/product link.
// The master drives requests and models Mul32; the slave is the controller.
interface hilo_mul_ctrl_if #(
   parameter int W = 32
);
   logic           start;
   logic           op_signed;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           hi_we;
   logic           lo_we;
   logic [W-1:0]   wdata;
   logic [W-1:0]   mul_a;
   logic [W-1:0]   mul_b;
   logic [2*W-1:0] mul_prod;
   logic [W-1:0]   hi;
   logic [W-1:0]   lo;
   logic           busy;
   logic           done;

   modport master (
      output start, op_signed, a, b, hi_we, lo_we, wdata, mul_prod,
      input  mul_a, mul_b, hi, lo, busy, done
   );

   modport slave (
      input  start, op_signed, a, b, hi_we, lo_we, wdata, mul_prod,
      output mul_a, mul_b, hi, lo, busy, done
   );
endinterface

// File: rtl/hilo_mul_ctrl.sv
// HI/LO multiply controller: feeds magnitudes to an unsigned Mul32,
// sign-fixes the captured product and owns the HI/LO pair.
module hilo_mul_ctrl #(
   parameter int W = 32
) (
   input  logic          clk,
   input  logic          rst,
   hilo_mul_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   hi_q, hi_d;
   logic [W-1:0]   lo_q, lo_d;
   logic [W-1:0]   mul_a_q, mul_a_d;
   logic [W-1:0]   mul_b_q, mul_b_d;
   logic [2*W-1:0] prod_q, prod_d;
   logic           neg_q, neg_d;
   logic           done_q, done_d;

   logic [W-1:0]   a_neg, b_neg;
   logic [2*W-1:0] prod_neg;

   assign a_neg    = -bus.a;
   assign b_neg    = -bus.b;
   assign prod_neg = ~prod_q + 1'b1;

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      mul_a_d = mul_a_q;
      mul_b_d = mul_b_q;
      prod_d  = prod_q;
      neg_d   = neg_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.hi_we) hi_d = bus.wdata;
            if (bus.lo_we) lo_d = bus.wdata;
            if (bus.start) begin
               // 0x8000_0000 negates to itself, which is its correct unsigned magnitude
               mul_a_d = (bus.op_signed && bus.a[W-1]) ? a_neg : bus.a;
               mul_b_d = (bus.op_signed && bus.b[W-1]) ? b_neg : bus.b;
               neg_d   = bus.op_signed & (bus.a[W-1] ^ bus.b[W-1]);
               state_d = CALC;
            end
         end
         CALC: begin
            prod_d  = bus.mul_prod;
            state_d = FIX;
         end
         FIX: begin
            {hi_d, lo_d} = neg_q ? prod_neg : prod_q;
            done_d       = 1'b1;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         hi_q    <= '0;
         lo_q    <= '0;
         mul_a_q <= '0;
         mul_b_q <= '0;
         prod_q  <= '0;
         neg_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         mul_a_q <= mul_a_d;
         mul_b_q <= mul_b_d;
         prod_q  <= prod_d;
         neg_q   <= neg_d;
         done_q  <= done_d;
      end
   end

   assign bus.mul_a = mul_a_q;
   assign bus.mul_b = mul_b_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;
   assign bus.busy  = (state_q != IDLE);
   assign bus.done  = done_q;
endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Directed bench for hilo_mul_ctrl with a behavioural Mul32 on the product input.
// Each scenario task drives vectors and checks hand-computed results.
module tb_hilo_mul_ctrl;
   logic clk;
   logic rst;
   int   pass_cnt;
   int   tot_cnt;

   hilo_mul_ctrl_if #(.W(32)) bus ();

   hilo_mul_ctrl #(.W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.mul_prod = {32'b0, bus.mul_a} * {32'b0, bus.mul_b};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.start     = 1'b0;
      bus.op_signed = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.hi_we     = 1'b0;
      bus.lo_we     = 1'b0;
      bus.wdata     = '0;
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tot_cnt++;
      if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
      else pass_cnt++;
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      tot_cnt++;
      if (act !== exp) $display("FAIL %s: got %b want %b", nm, act, exp);
      else pass_cnt++;
   endtask

   task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      bus.start     = 1'b1;
      bus.op_signed = sgn;
      bus.a         = a;
      bus.b         = b;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      step();
      step();
      chk32("rst_hi", bus.hi, 32'h0);
      chk32("rst_lo", bus.lo, 32'h0);
      chk32("rst_mul_a", bus.mul_a, 32'h0);
      chk32("rst_mul_b", bus.mul_b, 32'h0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_done", bus.done, 1'b0);
      rst = 1'b0;
      step();
   endtask

   task automatic test_multu_max();
      launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      step();
      idle_inputs();
      chk1("multu_busy_calc", bus.busy, 1'b1);
      chk32("multu_mul_a", bus.mul_a, 32'hFFFF_FFFF);
      chk1("multu_done_calc", bus.done, 1'b0);
      step();
      chk1("multu_busy_fix", bus.busy, 1'b1);
      chk1("multu_done_fix", bus.done, 1'b0);
      step();
      chk1("multu_done", bus.done, 1'b1);
      chk1("multu_busy_done", bus.busy, 1'b0);
      chk32("multu_hi", bus.hi, 32'hFFFF_FFFE);
      chk32("multu_lo", bus.lo, 32'h0000_0001);
      step();
      chk1("multu_done_once", bus.done, 1'b0);
   endtask

   task automatic test_mult_neg();
      launch(1'b1, 32'hFFFF_FFFD, 32'h0000_0005);
      step();
      idle_inputs();
      chk32("mult_mag_a", bus.mul_a, 32'h3);
      chk32("mult_mag_b", bus.mul_b, 32'h5);
      step();
      step();
      chk32("mult_hi", bus.hi, 32'hFFFF_FFFF);
      chk32("mult_lo", bus.lo, 32'hFFFF_FFF1);
      step();
   endtask

   task automatic test_most_negative();
      launch(1'b1, 32'h8000_0000, 32'h8000_0000);
      step();
      idle_inputs();
      chk32("minneg_mag_a", bus.mul_a, 32'h8000_0000);
      step();
      step();
      chk32("minneg_sq_hi", bus.hi, 32'h4000_0000);
      chk32("minneg_sq_lo", bus.lo, 32'h0);
      step();
      launch(1'b1, 32'h8000_0000, 32'h0000_0001);
      step();
      idle_inputs();
      step();
      step();
      chk32("minneg_x1_hi", bus.hi, 32'hFFFF_FFFF);
      chk32("minneg_x1_lo", bus.lo, 32'h8000_0000);
      step();
   endtask

   task automatic test_zero_neg();
      launch(1'b1, 32'h0, 32'hFFFF_FFFB);
      step();
      idle_inputs();
      step();
      step();
      chk32("zneg_hi", bus.hi, 32'h0);
      chk32("zneg_lo", bus.lo, 32'h0);
      step();
   endtask

   task automatic test_start_busy();
      launch(1'b0, 32'h2, 32'h3);
      step();
      launch(1'b0, 32'h7, 32'h3);
      chk1("sbusy_busy1", bus.busy, 1'b1);
      step();
      chk1("sbusy_busy2", bus.busy, 1'b1);
      step();
      idle_inputs();
      chk1("sbusy_idle", bus.busy, 1'b0);
      chk32("sbusy_hi", bus.hi, 32'h0);
      chk32("sbusy_lo", bus.lo, 32'h6);
      chk32("sbusy_hold_a", bus.mul_a, 32'h2);
      step();
      chk1("sbusy_no_restart", bus.busy, 1'b0);
      chk32("sbusy_hold_a2", bus.mul_a, 32'h2);
   endtask

   task automatic test_mt_write();
      bus.hi_we = 1'b1;
      bus.lo_we = 1'b1;
      bus.wdata = 32'hA5A5_5A5A;
      step();
      idle_inputs();
      chk32("mt_both_hi", bus.hi, 32'hA5A5_5A5A);
      chk32("mt_both_lo", bus.lo, 32'hA5A5_5A5A);
      launch(1'b0, 32'h2, 32'h3);
      bus.hi_we = 1'b1;
      bus.wdata = 32'h1234_5678;
      step();
      idle_inputs();
      chk32("mt_with_start_hi", bus.hi, 32'h1234_5678);
      chk32("mt_with_start_lo", bus.lo, 32'hA5A5_5A5A);
      bus.lo_we = 1'b1;
      bus.hi_we = 1'b1;
      bus.wdata = 32'hDEAD_BEEF;
      step();
      chk32("mt_busy_lo", bus.lo, 32'hA5A5_5A5A);
      chk32("mt_busy_hi", bus.hi, 32'h1234_5678);
      step();
      idle_inputs();
      chk32("mt_prod_hi", bus.hi, 32'h0);
      chk32("mt_prod_lo", bus.lo, 32'h6);
      step();
   endtask

   task automatic test_reset_in_fix();
      bus.hi_we = 1'b1;
      bus.wdata = 32'h0000_0001;
      step();
      idle_inputs();
      launch(1'b0, 32'h9, 32'h9);
      step();
      idle_inputs();
      step();
      chk1("rfix_in_fix", bus.busy, 1'b1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk1("rfix_busy", bus.busy, 1'b0);
      chk1("rfix_done", bus.done, 1'b0);
      chk32("rfix_hi", bus.hi, 32'h0);
      chk32("rfix_lo", bus.lo, 32'h0);
      step();
      chk32("rfix_no_write", bus.lo, 32'h0);
      launch(1'b0, 32'h4, 32'h4);
      step();
      idle_inputs();
      step();
      step();
      chk1("rfix_after_done", bus.done, 1'b1);
      chk32("rfix_after_hi", bus.hi, 32'h0);
      chk32("rfix_after_lo", bus.lo, 32'd16);
      step();
   endtask

   initial begin
      pass_cnt = 0;
      tot_cnt  = 0;
      rst      = 1'b1;
      idle_inputs();
      test_reset();
      test_multu_max();
      test_mult_neg();
      test_most_negative();
      test_zero_neg();
      test_start_busy();
      test_mt_write();
      test_reset_in_fix();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
